hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-002 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have ports Rs1D, Rs2D  input  5 each  decode-stage source registers.
REQ-004 SHALL have ports Rs1E, Rs2E, RdE  input  5 each  execute-stage sources and destination.
REQ-005 SHALL have ports RdM, RdW  input  5 each  memory- and writeback-stage destinations.
REQ-006 SHALL have ports RegWriteM, RegWriteW  input  1 each  stage register-write enables.
REQ-007 SHALL have port ResultSrcE  input  2  execute-stage result select; 2'b01 marks a load.
REQ-008 SHALL have port PCSrcE  input  1  taken branch or jump resolved in execute.
REQ-009 SHALL have ports MemReqM, MemReady  input  1 each  data-memory access in memory stage; memory ready.
REQ-010 SHALL have ports StallF, StallD, StallE, StallM  output  1 each  hold the stage register.
REQ-011 SHALL have ports FlushD, FlushE  output  1 each  FlushE drives the CLR input of the execute register.
REQ-012 SHALL have ports ForwardAE, ForwardBE  output  2 each  ALU operand select: 00 register file, 01 writeback, 10 memory.
REQ-013 SHALL have port HzState  output  2  registered state: 0 RUN, 1 LD_STALL, 2 BR_FLUSH, 3 MEM_WAIT.

Function
REQ-014 SHALL set ForwardAE=10 when RegWriteM, RdM!=0 and RdM==Rs1E; else 01 when RegWriteW, RdW!=0 and RdW==Rs1E; else 00. ForwardBE uses Rs2E the same way.
REQ-015 SHALL compute ld_hz = (ResultSrcE==01) & RdE!=0 & (RdE==Rs1D | RdE==Rs2D), combinationally in the same cycle.
REQ-016 SHALL compute mem_hz = MemReqM & !MemReady in the same cycle.
REQ-017 SHALL assert StallF=StallD=StallE=StallM=1 and FlushD=FlushE=0 while mem_hz=1 or HzState==MEM_WAIT with MemReady=0; priority 1, above all other hazards.
REQ-018 Otherwise, SHALL assert FlushD=FlushE=1 and StallF=StallD=0 when PCSrcE=1; priority 2, so a branch overrides a load-use hazard.
REQ-019 Otherwise, SHALL assert StallF=StallD=FlushE=1 when ld_hz=1; priority 3.
REQ-020 SHALL drive all stall and flush outputs 0 when no hazard is active.
REQ-021 SHALL update the state on each clk edge: MEM_WAIT if priority 1 is active, else BR_FLUSH if priority 2, else LD_STALL if priority 3, else RUN.
REQ-022 SHALL leave MEM_WAIT in the cycle MemReady=1; in that exit cycle, priorities 2 and 3 SHALL be evaluated normally.
REQ-023 SHALL apply a PCSrcE that is held during MEM_WAIT exactly once, on the exit cycle, and SHALL never flush while stalled.
REQ-024 SHALL ignore register index 0 for both forwarding and load-use detection.

Reset
REQ-025 SHALL, when rst_n=0 at a clk edge, set HzState=RUN and clear the counters in REQ-028.
REQ-026 SHALL hold every stall/flush output at 0 and ForwardAE=ForwardBE=00 while rst_n=0, regardless of other inputs.
REQ-027 SHALL abandon an in-progress MEM_WAIT on reset, with no pending flush retained.

Configuration
REQ-028 With macro HAZARD_PERF_CNT_EN defined, SHALL add outputs StallCnt[31:0] (cycles with StallF=1) and FlushCnt[31:0] (cycles with FlushE=1). Both SHALL saturate at 0xFFFFFFFF.
REQ-029 Without HAZARD_PERF_CNT_EN, those ports and counters SHALL be absent, and the remaining behaviour SHALL be identical.

Structure
REQ-030 SHALL import hazard_pkg, which holds the hz_state_t enum, forward codes FWD_RF/FWD_WB/FWD_MEM and RESULT_SRC_LOAD=2'b01.
REQ-031 SHALL instantiate the sub-module forward_sel twice (operand A, operand B); forward_sel is purely combinational. The FSM and counters SHALL stay in hazard_ctrl.

Verification
REQ-032 SHALL test forwarding: RegWriteM=1, RdM=5, Rs1E=5, RegWriteW=1, RdW=5 -> ForwardAE=10. Then RdM=6 -> ForwardAE=01. Then RdW=0 -> 00.
REQ-033 SHALL test load-use: ResultSrcE=01, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle, and HzState=LD_STALL on the next cycle.
REQ-034 SHALL test branch over load-use: PCSrcE=1 with ld_hz=1 -> FlushD=FlushE=1 and StallF=0.
REQ-035 SHALL test memory wait: MemReqM=1, MemReady=0 for 3 cycles with PCSrcE=1 -> all four stalls=1 and no flush for 3 cycles. On MemReady=1 -> FlushD=FlushE=1 exactly once.
REQ-036 SHALL test reset mid-MEM_WAIT: rst_n=0 for 1 cycle -> HzState=RUN, all outputs 0, and counters=0 when enabled.
REQ-037 With HAZARD_PERF_CNT_EN, SHALL test saturation: preload StallCnt=0xFFFFFFFE, then 3 stall cycles -> StallCnt=0xFFFFFFFF.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard unit.
package hazard_pkg;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_LD_STALL = 2'd1,
    HZ_BR_FLUSH = 2'd2,
    HZ_MEM_WAIT = 2'd3
  } hz_state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/hazard_if.sv
// Pipeline <-> hazard unit signal bundle; master is the pipeline, slave the hazard unit.
interface hazard_if;
  logic [4:0] Rs1D, Rs2D;
  logic [4:0] Rs1E, Rs2E, RdE;
  logic [4:0] RdM, RdW;
  logic       RegWriteM, RegWriteW;
  logic [1:0] ResultSrcE;
  logic       PCSrcE;
  logic       MemReqM, MemReady;
  logic       StallF, StallD, StallE, StallM;
  logic       FlushD, FlushE;
  logic [1:0] ForwardAE, ForwardBE;
  logic [1:0] HzState;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
           ResultSrcE, PCSrcE, MemReqM, MemReady,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE,
           ForwardAE, ForwardBE, HzState
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, RegWriteM, RegWriteW,
           ResultSrcE, PCSrcE, MemReqM, MemReady,
    output StallF, StallD, StallE, StallM, FlushD, FlushE,
           ForwardAE, ForwardBE, HzState
  );
endinterface

// File: rtl/hazard_ctrl_forward_sel.sv
// Combinational ALU operand bypass select for one execute-stage source register.
module forward_sel
  import hazard_pkg::*;
(
  input  logic       en,
  input  logic [4:0] rs,
  input  logic [4:0] rd_m,
  input  logic       regwrite_m,
  input  logic [4:0] rd_w,
  input  logic       regwrite_w,
  output logic [1:0] fwd
);

  // x0 is hard-wired zero and must never be bypassed.
  always_comb begin
    fwd = FWD_RF;
    if (en) begin
      if (regwrite_m && (rd_m != '0) && (rd_m == rs))
        fwd = FWD_MEM;
      else if (regwrite_w && (rd_w != '0) && (rd_w == rs))
        fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use stall, branch flush, memory wait.
// Optional perf counters (StallCnt/FlushCnt) enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  hazard_if.slave     hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] StallCnt,
  output logic [31:0] FlushCnt
`endif
);

  hz_state_t state;
  logic      ld_hz, mem_hz;
  logic      pri_mem, pri_br, pri_ld;

  forward_sel u_fwd_a (
    .en         (rst_n),
    .rs         (hz.Rs1E),
    .rd_m       (hz.RdM),
    .regwrite_m (hz.RegWriteM),
    .rd_w       (hz.RdW),
    .regwrite_w (hz.RegWriteW),
    .fwd        (hz.ForwardAE)
  );

  forward_sel u_fwd_b (
    .en         (rst_n),
    .rs         (hz.Rs2E),
    .rd_m       (hz.RdM),
    .regwrite_m (hz.RegWriteM),
    .rd_w       (hz.RdW),
    .regwrite_w (hz.RegWriteW),
    .fwd        (hz.ForwardBE)
  );

  always_comb begin
    ld_hz  = (hz.ResultSrcE == RESULT_SRC_LOAD) && (hz.RdE != '0) &&
             ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
    mem_hz = hz.MemReqM && !hz.MemReady;
  end

  // Strict priority; a branch seen during a memory wait is applied by the
  // pipeline on the exit cycle because PCSrcE is simply re-evaluated then.
  always_comb begin
    pri_mem = rst_n && (mem_hz || ((state == HZ_MEM_WAIT) && !hz.MemReady));
    pri_br  = rst_n && !pri_mem && hz.PCSrcE;
    pri_ld  = rst_n && !pri_mem && !pri_br && ld_hz;
  end

  always_comb begin
    hz.StallF  = pri_mem || pri_ld;
    hz.StallD  = pri_mem || pri_ld;
    hz.StallE  = pri_mem;
    hz.StallM  = pri_mem;
    hz.FlushD  = pri_br;
    hz.FlushE  = pri_br || pri_ld;
    hz.HzState = state;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= HZ_RUN;
    else if (pri_mem)
      state <= HZ_MEM_WAIT;
    else if (pri_br)
      state <= HZ_BR_FLUSH;
    else if (pri_ld)
      state <= HZ_LD_STALL;
    else
      state <= HZ_RUN;
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (hz.StallF) stall_cnt <= sat_inc(stall_cnt);
      if (hz.FlushE) flush_cnt <= sat_inc(flush_cnt);
    end
  end

  assign StallCnt = stall_cnt;
  assign FlushCnt = flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (counter checks when HAZARD_PERF_CNT_EN is defined).
module tb_hazard_ctrl;
  import hazard_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  hazard_if hif ();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] StallCnt, FlushCnt;
  hazard_ctrl dut (.clk(clk), .rst_n(rst_n), .hz(hif.slave),
                   .StallCnt(StallCnt), .FlushCnt(FlushCnt));
`else
  hazard_ctrl dut (.clk(clk), .rst_n(rst_n), .hz(hif.slave));
`endif

  // {StallF, StallD, StallE, StallM, FlushD, FlushE}
  logic [5:0] ctl;
  assign ctl = {hif.StallF, hif.StallD, hif.StallE, hif.StallM, hif.FlushD, hif.FlushE};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    hif.Rs1D = '0; hif.Rs2D = '0; hif.Rs1E = '0; hif.Rs2E = '0; hif.RdE = '0;
    hif.RdM = '0; hif.RdW = '0; hif.RegWriteM = 1'b0; hif.RegWriteW = 1'b0;
    hif.ResultSrcE = 2'b00; hif.PCSrcE = 1'b0; hif.MemReqM = 1'b0; hif.MemReady = 1'b1;
  endtask

  // Move to the next negative edge, then let combinational outputs settle after new drives.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    // Reset with every hazard source active: all outputs must stay quiet.
    hif.PCSrcE = 1'b1; hif.MemReqM = 1'b1; hif.MemReady = 1'b0;
    hif.ResultSrcE = 2'b01; hif.RdE = 5'd3; hif.Rs1D = 5'd3;
    hif.RegWriteM = 1'b1; hif.RdM = 5'd4; hif.Rs1E = 5'd4; hif.Rs2E = 5'd4;
    #1;
    check("rst_ctl", 32'(ctl), 32'h0);
    check("rst_fwdA", 32'(hif.ForwardAE), 32'(FWD_RF));
    check("rst_fwdB", 32'(hif.ForwardBE), 32'(FWD_RF));
    next_cycle(); next_cycle();
    check("rst_state", 32'(hif.HzState), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    check("rst_stallcnt", StallCnt, 32'd0);
    check("rst_flushcnt", FlushCnt, 32'd0);
`endif

    // Forwarding
    clear_inputs();
    rst_n = 1'b1;
    hif.RegWriteM = 1'b1; hif.RdM = 5'd5; hif.Rs1E = 5'd5; hif.RegWriteW = 1'b1; hif.RdW = 5'd5;
    #1 check("fwdA_mem", 32'(hif.ForwardAE), 32'd2);
    check("fwd_noctl", 32'(ctl), 32'h0);
    hif.RdM = 5'd6;
    #1 check("fwdA_wb", 32'(hif.ForwardAE), 32'd1);
    hif.RdW = 5'd0;
    #1 check("fwdA_rf", 32'(hif.ForwardAE), 32'd0);
    hif.Rs2E = 5'd6; hif.RegWriteM = 1'b0;
    #1 check("fwdB_nowr", 32'(hif.ForwardBE), 32'd0);
    hif.RegWriteM = 1'b1;
    #1 check("fwdB_mem", 32'(hif.ForwardBE), 32'd2);
    hif.RdM = 5'd0; hif.Rs1E = 5'd0; hif.RdW = 5'd0; hif.Rs2E = 5'd0;
    #1 check("fwd_x0", 32'({hif.ForwardAE, hif.ForwardBE}), 32'd0);
    next_cycle();
    check("run_state", 32'(hif.HzState), 32'd0);

    // Load-use
    clear_inputs();
    hif.ResultSrcE = 2'b01; hif.RdE = 5'd7; hif.Rs2D = 5'd7;
    #1 check("lduse_ctl", 32'(ctl), 32'h31);
    next_cycle();
    clear_inputs();
    #1 check("lduse_state", 32'(hif.HzState), 32'd1);
    check("lduse_once", 32'(ctl), 32'h0);
    hif.ResultSrcE = 2'b01; hif.RdE = 5'd0; hif.Rs1D = 5'd0;
    #1 check("lduse_x0", 32'(ctl), 32'h0);
    next_cycle();

    // Branch beats load-use
    clear_inputs();
    hif.ResultSrcE = 2'b01; hif.RdE = 5'd7; hif.Rs2D = 5'd7; hif.PCSrcE = 1'b1;
    #1 check("br_ctl", 32'(ctl), 32'h03);
    next_cycle();
    check("br_state", 32'(hif.HzState), 32'd2);

    // Memory wait with a pending branch
    clear_inputs();
    hif.PCSrcE = 1'b1; hif.MemReqM = 1'b1; hif.MemReady = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      if (i == 2) hif.MemReqM = 1'b0;  // held in MEM_WAIT by state alone
      #1 check($sformatf("memw_ctl%0d", i), 32'(ctl), 32'h3C);
      next_cycle();
      check($sformatf("memw_state%0d", i), 32'(hif.HzState), 32'd3);
    end
    hif.MemReqM = 1'b1; hif.MemReady = 1'b1;
    #1 check("memw_exit_ctl", 32'(ctl), 32'h03);
    next_cycle();
    check("memw_exit_state", 32'(hif.HzState), 32'd2);
    clear_inputs();
    #1 check("memw_flush_once", 32'(ctl), 32'h0);
    next_cycle();
    check("memw_back_run", 32'(hif.HzState), 32'd0);

    // Reset during MEM_WAIT
    hif.PCSrcE = 1'b1; hif.MemReqM = 1'b1; hif.MemReady = 1'b0;
    next_cycle(); next_cycle();
    check("pre_rst_state", 32'(hif.HzState), 32'd3);
    rst_n = 1'b0;
    #1 check("rstw_ctl", 32'(ctl), 32'h0);
    next_cycle();
    check("rstw_state", 32'(hif.HzState), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    check("rstw_stallcnt", StallCnt, 32'd0);
    check("rstw_flushcnt", FlushCnt, 32'd0);
`endif
    clear_inputs();
    rst_n = 1'b1;
    #1 check("rstw_noflush", 32'(ctl), 32'h0);
    next_cycle();
    check("rstw_run", 32'(hif.HzState), 32'd0);

`ifdef HAZARD_PERF_CNT_EN
    // Counting and saturation
    hif.ResultSrcE = 2'b01; hif.RdE = 5'd9; hif.Rs1D = 5'd9;
    next_cycle();
    check("cnt_stall1", StallCnt, 32'd1);
    check("cnt_flush1", FlushCnt, 32'd1);
    force dut.stall_cnt = 32'hFFFF_FFFE;
    #1 release dut.stall_cnt;
    for (int unsigned i = 0; i < 3; i++) next_cycle();
    check("cnt_sat", StallCnt, 32'hFFFF_FFFF);
    clear_inputs();
`endif

    next_cycle();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
